sram_axi_slave: RTL and testbench
=================================

SRAM_AXI_SLAVE -- requirements
Module: sram_axi_slave

Interface
REQ-001 The block SHALL have parameters ID_BITS, default 8, meaning slave-side AXI ID width (4-bit master ID plus 4-bit master-select prefix).
REQ-002 The block SHALL have parameters ADDR_BITS 32, DATA_BITS 32, LEN_BITS 4 and SRAM_AW 14, the last meaning SRAM word-address width.
REQ-003 The block SHALL have clk, an input of width 1, as the clock; all logic is posedge clk.
REQ-004 The block SHALL have rstn, an input of width 1, as the reset: asynchronous, active-low.
REQ-005 The block SHALL have the AW channel: inputs AWID[ID_BITS], AWADDR[32], AWLEN[4], AWSIZE[3], AWBURST[2] and AWVALID; output AWREADY.
REQ-006 The block SHALL have the W channel: inputs WDATA[32], WSTRB[4], WLAST and WVALID; output WREADY.
REQ-007 The block SHALL have the B channel: outputs BID[ID_BITS], BRESP[2] and BVALID; input BREADY.
REQ-008 The block SHALL have the AR channel: inputs ARID, ARADDR, ARLEN, ARSIZE, ARBURST and ARVALID, with widths as for AW; output ARREADY.
REQ-009 The block SHALL have the R channel: outputs RID[ID_BITS], RDATA[32], RRESP[2], RLAST and RVALID; input RREADY.
REQ-010 The block SHALL have the SRAM port: outputs CEB, WEB, BWEB[32], A[SRAM_AW] and DI[32]; input DO[32]. CEB, WEB and BWEB are active-low, and the read latency is 1 cycle.

Function
REQ-011 The FSM SHALL have states IDLE, READ, WRITE and WRESP, and only one transaction SHALL be in flight at any time.
REQ-012 In IDLE: AWREADY=1 and ARREADY=~AWVALID, so a write wins when AWVALID and ARVALID are both high in the same cycle; both READYs SHALL be 0 in every other state.
REQ-013 On an AR handshake: latch ID, word address ARADDR[SRAM_AW+1:2] and LEN; clear the beat counter; drive A=ARADDR word with CEB=0 in the same cycle; go to READ.
REQ-014 In READ: RVALID=1, RDATA=DO, RID=latched ID, RRESP=2'b00, and RLAST=1 when beat counter == LEN.
REQ-015 In READ, A SHALL be address_reg+1 on an R handshake that is not last, and address_reg otherwise, so DO stays stable while RREADY=0.
REQ-016 An R handshake with RLAST SHALL return to IDLE; otherwise it SHALL increment the address and the beat counter.
REQ-017 On an AW handshake: latch ID, word address and LEN; clear the beat counter and the error flag; go to WRITE.
REQ-018 In WRITE: WREADY=1. On a W handshake: CEB=0, WEB=0, A=address_reg, DI=WDATA, and BWEB[8i+7:8i]=~{8{WSTRB[i]}} for i=0..3.
REQ-019 Write burst termination SHALL be by beat counter == LEN, not by WLAST. Any beat whose WLAST differs from (counter==LEN) SHALL set the error flag. The final beat SHALL go to WRESP.
REQ-020 In WRESP: BVALID=1, BID=latched ID, BRESP=2'b10 (SLVERR) if the error flag is set, else 2'b00. A B handshake SHALL return to IDLE.
REQ-021 Outside write beats: WEB=1 and BWEB=32'hFFFF_FFFF.
REQ-022 Outside read issue/hold cycles and write beats: CEB=1.
REQ-023 Only INCR bursts with 4-byte beats SHALL be supported: AWSIZE, ARSIZE, AWBURST and ARBURST are ignored, and the word address SHALL increment by 1 per beat, wrapping modulo 2^SRAM_AW.
REQ-024 The beat counter SHALL be LEN_BITS wide, so a burst has at most 16 beats.
REQ-025 RVALID and BVALID, once asserted, SHALL hold with stable payload until their handshake completes.

Reset
REQ-026 On rstn=0 the block SHALL immediately enter IDLE, regardless of any transaction in progress.
REQ-027 On rstn=0 the output values SHALL be: AWREADY=1 and ARREADY=1 (follow IDLE rules); WREADY, BVALID, RVALID and RLAST=0; BID, RID, BRESP, RRESP and RDATA-hold=0; CEB=1, WEB=1, BWEB=all ones; A=0; DI=0.
REQ-028 A transaction interrupted by reset SHALL be dropped, with no B or R response issued after reset release.

Verification
REQ-029 Single write, then single read: AW(ID=8'h11, ADDR=0x0000_0010, LEN=0) + W(0xDEADBEEF, STRB=4'hF, WLAST=1) -> SRAM write at A=4, then BRESP=00 and BID=8'h11. A following AR to the same address -> RDATA=0xDEADBEEF, RLAST=1 in the cycle after the AR handshake.
REQ-030 Byte strobe: prefill 0xDEADBEEF at word 4, then write 0x12345678 with STRB=4'b0101 -> BWEB=0xFF00FF00, and a readback returns 0xDE34BE78.
REQ-031 Read burst with backpressure: LEN=3 at 0x100, RREADY toggling 1,0,0,1 -> four beats of words 0x40..0x43 in order, RDATA stable while stalled, RLAST only on the 4th beat.
REQ-032 AW and AR valid in the same cycle -> AWREADY=1 and ARREADY=0; the read is accepted only after the write's B handshake.
REQ-033 Write LEN=1 with WLAST=1 on the first beat -> both beats written, BRESP=2'b10.
REQ-034 Reset during beat 2 of a LEN=3 read -> after release RVALID=0, state IDLE, and a new AR is accepted normally.

Source files
------------

// File: rtl/sram_axi_slave_if.sv
// sram_axi_slave_if: AXI4 write/read channel bundle between a master and the SRAM slave
interface sram_axi_slave_if #(
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4
) ();
  logic [ID_BITS-1:0]     awid;
  logic [ADDR_BITS-1:0]   awaddr;
  logic [LEN_BITS-1:0]    awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  logic [ID_BITS-1:0]     bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [ID_BITS-1:0]     arid;
  logic [ADDR_BITS-1:0]   araddr;
  logic [LEN_BITS-1:0]    arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;
  logic [ID_BITS-1:0]     rid;
  logic [DATA_BITS-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/sram_axi_slave.sv
// sram_axi_slave: single-outstanding AXI4 INCR slave in front of a 1-cycle-latency SRAM
module sram_axi_slave #(
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SRAM_AW   = 14
) (
  input  logic                 clk,
  input  logic                 rstn,
  sram_axi_slave_if.slave      bus,
  output logic                 ceb_o,
  output logic                 web_o,
  output logic [DATA_BITS-1:0] bweb_o,
  output logic [SRAM_AW-1:0]   a_o,
  output logic [DATA_BITS-1:0] di_o,
  input  logic [DATA_BITS-1:0] do_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;

  state_t              state_q, state_d;
  logic [ID_BITS-1:0]  id_q, id_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                last;
  logic                unused_bits;

  assign last = cnt_q == len_q;

  // Size/burst are fixed to 4-byte INCR, and only the word-address bits reach the SRAM
  assign unused_bits = ^{bus.awsize, bus.arsize, bus.awburst, bus.arburst,
                         bus.awaddr[ADDR_BITS-1:SRAM_AW+2], bus.awaddr[1:0],
                         bus.araddr[ADDR_BITS-1:SRAM_AW+2], bus.araddr[1:0]};

  // Transaction state; reset drops any burst in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state, AXI handshakes and SRAM strobes; writes win over reads in IDLE
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    bus.awready = 1'b0;
    bus.arready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = '0;
    bus.bresp   = 2'b00;
    bus.rvalid  = 1'b0;
    bus.rid     = '0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    ceb_o       = 1'b1;
    web_o       = 1'b1;
    bweb_o      = '1;
    a_o         = '0;
    di_o        = '0;
    case (state_q)
      IDLE: begin
        bus.awready = 1'b1;
        bus.arready = ~bus.awvalid;
        if (bus.awvalid) begin
          id_d    = bus.awid;
          addr_d  = bus.awaddr[SRAM_AW+1:2];
          len_d   = bus.awlen;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = WRITE;
        end else if (bus.arvalid) begin
          id_d    = bus.arid;
          addr_d  = bus.araddr[SRAM_AW+1:2];
          len_d   = bus.arlen;
          cnt_d   = '0;
          ceb_o   = 1'b0;
          a_o     = bus.araddr[SRAM_AW+1:2];
          state_d = READ;
        end
      end
      READ: begin
        bus.rvalid = 1'b1;
        bus.rid    = id_q;
        bus.rdata  = do_i;
        bus.rlast  = last;
        ceb_o      = 1'b0;
        a_o        = addr_q;
        if (bus.rready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            a_o    = addr_q + 1'b1;
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          ceb_o = 1'b0;
          web_o = 1'b0;
          a_o   = addr_q;
          di_o  = bus.wdata;
          for (int i = 0; i < DATA_BITS/8; i++) bweb_o[8*i +: 8] = ~{8{bus.wstrb[i]}};
          if (bus.wlast != last) err_d = 1'b1;
          if (last) begin
            state_d = WRESP;
          end else begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      WRESP: begin
        bus.bvalid = 1'b1;
        bus.bid    = id_q;
        bus.bresp  = err_q ? 2'b10 : 2'b00;
        if (bus.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// tb_sram_axi_slave: scoreboard bench driving AXI bursts against an SRAM model
module tb_sram_axi_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ceb, web;
  logic [31:0] bweb, di, dout;
  logic [13:0] a;

  sram_axi_slave_if #(.ID_BITS(8), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4)) bus ();

  sram_axi_slave #(.ID_BITS(8), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4), .SRAM_AW(14)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .ceb_o(ceb), .web_o(web), .bweb_o(bweb), .a_o(a), .di_o(di), .do_i(dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];

  // SRAM model: byte-masked write, registered read
  always @(posedge clk) begin
    if (!ceb) begin
      if (!web) begin
        for (int i = 0; i < 4; i++) if (!bweb[8*i]) mem[a][8*i +: 8] <= di[8*i +: 8];
      end else begin
        dout <= mem[a];
      end
    end
  end

  typedef struct { logic [7:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [7:0] id; logic [31:0] data; logic last; } r_t;
  b_t b_q[$];
  r_t r_q[$];

  int checks = 0;
  int failures = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_beats(input int len);
    for (int b = 0; b < 16; b++) begin
      wd[b] = 32'hA5A5_0000 + 32'(b * 32'h0101);
      ws[b] = 4'hF;
      wl[b] = (b == len);
    end
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int len, input logic [1:0] resp);
    int n;
    logic [13:0] w;
    logic [31:0] eb;
    b_t e;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len[3:0]; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_ready", bus.awready, 1);
    chk("ar_blocked_by_aw", bus.arready, 0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    b_q.push_back('{id: id, resp: resp});
    for (int b = 0; b <= len; b++) begin
      bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = wl[b]; bus.wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      w = addr[15:2] + 14'(b);
      for (int i = 0; i < 4; i++) eb[8*i +: 8] = {8{~ws[b][i]}};
      chk("w_ready", bus.wready, 1);
      chk("w_ceb_web", {ceb, web}, 2'b00);
      chk("w_addr", a, w);
      chk("w_bweb", bweb, eb);
      chk("w_di", di, wd[b]);
      chk("ar_blocked_w", bus.arready, 0);
      for (int i = 0; i < 4; i++) if (ws[b][i]) ref_mem[w][8*i +: 8] = wd[b][8*i +: 8];
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    @(negedge clk);
    chk("w_idle_strobes", {ceb, web, bweb}, {2'b11, 32'hFFFF_FFFF});
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", bus.bvalid, 1);
    chk("ar_blocked_b", bus.arready, 0);
    if (b_q.size() > 0) begin
      e = b_q.pop_front();
      chk("b_id", bus.bid, e.id);
      chk("b_resp", bus.bresp, e.resp);
    end else chk("b_unexpected", 1, 0);
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len, input logic [3:0] pat, input int abort);
    int n;
    int got;
    r_t e;
    bus.arid = id; bus.araddr = addr; bus.arlen = len[3:0]; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_ready", bus.arready, 1);
    chk("ar_ceb", ceb, 0);
    chk("ar_addr", a, addr[15:2]);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int b = 0; b <= len; b++)
      r_q.push_back('{id: id, data: ref_mem[14'(addr[15:2] + 14'(b))], last: (b == len)});
    got = 0;
    for (int k = 0; got <= len && k < 200; k++) begin
      bus.rready = pat[k % 4];
      @(negedge clk);
      if (k == 0) chk("r_first_valid", bus.rvalid, 1);
      if (bus.rvalid) begin
        if (r_q.size() == 0) chk("r_unexpected", 1, 0);
        else if (bus.rready) begin
          e = r_q.pop_front();
          chk("r_data", bus.rdata, e.data);
          chk("r_last", bus.rlast, e.last);
          chk("r_id", bus.rid, e.id);
          chk("r_resp", bus.rresp, 2'b00);
          got++;
        end else begin
          chk("r_stall_data", bus.rdata, r_q[0].data);
          chk("r_stall_last", bus.rlast, r_q[0].last);
        end
      end
      @(posedge clk); #1;
      if (abort > 0 && got == abort) break;
    end
    bus.rready = 1'b0;
    if (abort == 0) chk("r_beats", got, len + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {bus.awready, bus.arready, bus.wready}, 3'b110);
    chk("rst_valid", {bus.bvalid, bus.rvalid, bus.rlast}, 3'b000);
    chk("rst_ids", {bus.bid, bus.rid, bus.bresp, bus.rresp}, 20'h0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_sram", {ceb, web, bweb}, {2'b11, 32'hFFFF_FFFF});
    chk("rst_addr_di", {a, di}, 46'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    set_beats(0); wd[0] = 32'hDEADBEEF;
    axi_write(8'h11, 32'h10, 0, 2'b00);
    axi_read(8'h22, 32'h10, 0, 4'b1111, 0);
    set_beats(0); wd[0] = 32'h12345678; ws[0] = 4'b0101;
    axi_write(8'h12, 32'h10, 0, 2'b00);
    axi_read(8'h23, 32'h10, 0, 4'b1111, 0);
    chk("strobe_model", ref_mem[4], 32'hDE34BE78);
    set_beats(3); wd[0] = 32'h0000_A0A0; wd[1] = 32'h1111_A1A1; wd[2] = 32'h2222_A2A2; wd[3] = 32'h3333_A3A3;
    axi_write(8'h31, 32'h100, 3, 2'b00);
    axi_read(8'h33, 32'h100, 3, 4'b1001, 0);
    bus.arid = 8'h44; bus.araddr = 32'h100; bus.arlen = '0; bus.arvalid = 1'b1;
    set_beats(0); wd[0] = 32'hCAFE_F00D;
    axi_write(8'h55, 32'h200, 0, 2'b00);
    axi_read(8'h44, 32'h100, 0, 4'b1111, 0);
    set_beats(1); wl[0] = 1'b1; wl[1] = 1'b1; wd[0] = 32'h0BAD_0001; wd[1] = 32'h0BAD_0002;
    axi_write(8'h66, 32'h300, 1, 2'b10);
    axi_read(8'h67, 32'h300, 1, 4'b1111, 0);
    set_beats(1); wl[1] = 1'b0;
    axi_write(8'h68, 32'h380, 1, 2'b10);
    set_beats(1); wd[0] = 32'h7777_EEEE; wd[1] = 32'h8888_FFFF;
    axi_write(8'h71, 32'hFFFC, 1, 2'b00);
    axi_read(8'h72, 32'hFFFC, 1, 4'b1111, 0);
    axi_read(8'h81, 32'h100, 3, 4'b1111, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.rvalid, 0);
    chk("mid_rst_ready", {bus.awready, bus.arready}, 2'b11);
    chk("mid_rst_ceb", ceb, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    r_q.delete();
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {bus.rvalid, bus.bvalid, bus.awready, bus.arready}, 4'b0011);
    @(posedge clk); #1;
    axi_read(8'h82, 32'h104, 1, 4'b1111, 0);
    chk("sb_empty", r_q.size() + b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
